pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the CPU fetch stage. It adds configurable width, reset vector and increment step, plus stall, absolute jump and PC-relative branch. A hardware return-address stack (RAS) provides call/return, with overflow/underflow detection. It drives the instruction-memory address each cycle.

Parameters:
WIDTH, 32, PC and offset/target bit width
RESET_VECTOR, 0, PC value loaded on reset
INCR, 1, sequential increment (1 = word-addressed, 4 = byte-addressed)
RAS_DEPTH, 8, return-address stack entries (power of two, >= 2)
TRAP_VECTOR, 32'hFFFF_FFF0, PC loaded on a return with an empty stack (truncated to WIDTH)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
stall  input  1  hold the PC; all other requests are ignored
branch_taken  input  1  PC-relative branch request (legacy "zero" semantics)
branch_offset  input  WIDTH  signed two's-complement offset
jump  input  1  absolute jump request
call  input  1  call request: push return address, jump to target
ret  input  1  return request: pop stack into PC
target  input  WIDTH  absolute target for jump/call
clr_err  input  1  clears sticky error flags
pc_out  output  WIDTH  current PC (registered)
ras_count  output  clog2(RAS_DEPTH)+1  valid stack entries
ras_empty  output  1  ras_count == 0
ras_full  output  1  ras_count == RAS_DEPTH
err_overflow  output  1  sticky: a call was made while the stack was full
err_underflow  output  1  sticky: a return was made while the stack was empty

Behaviour:
- Reset (asynchronous, any time including mid-operation): pc_out=RESET_VECTOR, ras_count=0, stack pointer=0, err_overflow=0, err_underflow=0. Stack contents are don't-care. The first update occurs on the first rising clk edge after rst deasserts.
- All state updates on rising clk. pc_out changes one cycle after a request is sampled; there is no combinational path from inputs to pc_out.
- Priority, one action per cycle: stall > ret > call > jump > branch_taken > sequential.
  - stall: pc_out, stack and flags hold. clr_err is still honoured.
  - ret, stack non-empty: pc_out <= top entry; ras_count decrements.
  - ret, stack empty: pc_out <= TRAP_VECTOR; err_underflow <= 1; ras_count stays 0.
  - call: push pc_out+INCR; pc_out <= target.
    - If the stack is full, overwrite the oldest entry (circular buffer). ras_count stays RAS_DEPTH and err_overflow <= 1.
  - jump: pc_out <= target.
  - branch_taken: pc_out <= pc_out + branch_offset. The offset is sign-interpreted.
  - otherwise: pc_out <= pc_out + INCR.
- Arithmetic is modulo 2^WIDTH. Wrap-around is silent, e.g. max value + INCR wraps to INCR-1.
- Simultaneous lower-priority requests are dropped, not queued.
- Sticky flags: set wins over clr_err in the same cycle. clr_err alone clears both flags.
- ras_empty and ras_full are combinational decodes of registered ras_count.
- Stack: RAS_DEPTH x WIDTH register array with a wrapping top-of-stack pointer. Push writes at ptr and then increments ptr; pop reads ptr-1 and then decrements ptr.

Test Plan:
- Reset then 3 idle cycles (WIDTH=32, INCR=1) -> pc_out 0,1,2,3. Assert rst asynchronously mid-cycle -> pc_out=0 immediately, before the next edge.
- At pc_out=10, branch_taken=1 with offset=-4 (32'hFFFF_FFFC) -> pc_out=6. Then offset=5 -> 11. With stall=1 and branch_taken=1 -> pc_out holds 11.
- At pc_out=20, call target=100 -> pc_out=100, ras_count=1. Then 2 idle cycles -> 102. Then ret -> pc_out=21, ras_count=0, ras_empty=1.
- RAS_DEPTH=8: 9 consecutive calls (targets 200..208, each issued from a distinct PC) -> err_overflow=1, ras_count=8. Then 8 rets return the 8 newest return addresses in LIFO order. A 9th ret -> pc_out=TRAP_VECTOR, err_underflow=1.
- Same cycle ret=1, call=1, jump=1 with one stack entry -> ret wins. Same cycle clr_err=1 with an underflowing ret -> err_underflow remains 1. Next cycle clr_err alone -> both flags 0.
- pc_out=32'hFFFF_FFFF, idle -> pc_out=0 (wrap). With INCR=4 from 32'hFFFF_FFFC -> 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with stall, absolute jump,
// PC-relative branch and a circular return-address stack (RAS).
//
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   stall                 hold PC, stack and flags (clr_err still works)
//   branch_taken/offset   pc <= pc + signed offset
//   jump/target           pc <= target
//   call                  push pc+INCR, pc <= target
//   ret                   pop stack into pc (TRAP_VECTOR if empty)
//   clr_err               clear sticky error flags
//   pc_out                registered PC / instruction-memory address
//   ras_count/empty/full  stack occupancy
//   err_overflow/underflow sticky stack error flags
module pc_sequencer #(
    parameter int WIDTH        = 32,
    parameter     RESET_VECTOR = 0,
    parameter int INCR         = 1,
    parameter int RAS_DEPTH    = 8,
    parameter     TRAP_VECTOR  = 32'hFFFF_FFF0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           branch_taken,
    input  logic [WIDTH-1:0]               branch_offset,
    input  logic                           jump,
    input  logic                           call,
    input  logic                           ret,
    input  logic [WIDTH-1:0]               target,
    input  logic                           clr_err,
    output logic [WIDTH-1:0]               pc_out,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           err_overflow,
    output logic                           err_underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(INCR);
    localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push;
    logic [PW-1:0]    ptr_m1;
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];

    assign ptr_m1 = ptr_q - PW'(1);

    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        // Clear first so a same-cycle set below takes precedence.
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (!stall) begin
            if (ret) begin
                if (cnt_q != '0) begin
                    pc_d  = stack_q[ptr_m1];
                    ptr_d = ptr_m1;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    pc_d  = TRAP_PC;
                    unf_d = 1'b1;
                end
            end else if (call) begin
                // When full, ptr already points at the oldest entry, so the
                // push overwrites it and the count saturates.
                push  = 1'b1;
                pc_d  = target;
                ptr_d = ptr_q + PW'(1);
                if (cnt_q == FULL_CNT) ovf_d = 1'b1;
                else                   cnt_d = cnt_q + CW'(1);
            end else if (jump) begin
                pc_d = target;
            end else if (branch_taken) begin
                pc_d = pc_q + branch_offset;
            end else begin
                pc_d = pc_q + STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RST_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack contents need no reset; only ptr/count define validity.
    always_ff @(posedge clk) begin
        if (push) stack_q[ptr_q] <= pc_q + STEP;
    end

    assign pc_out        = pc_q;
    assign ras_count     = cnt_q;
    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == FULL_CNT);
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
endmodule
